// File: rtl/image_encrypter_if.sv
// image_encrypter_if: control, plaintext-ROM read and ciphertext-RAM write signals of the encrypter
interface image_encrypter_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [63:0]       key;
    logic              encrypter_active;
    logic [7:0]        plain_data;
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [7:0]        encrypted_data;
    logic              write_en;
    logic              busy;
    logic              done;

    // master is the encrypter: it drives the memory addresses, the write strobe and the status flags
    modport master (
        input  start, key, encrypter_active, plain_data,
        output read_addr, write_addr, encrypted_data, write_en, busy, done
    );

    // slave is the surrounding system: it issues commands and returns ROM data
    modport slave (
        output start, key, encrypter_active, plain_data,
        input  read_addr, write_addr, encrypted_data, write_en, busy, done
    );
endinterface

// File: rtl/image_encrypter.sv
// image_encrypter: streams an image from ROM through a keyed byte cipher into RAM at 3 active cycles per byte
module image_encrypter #(
    parameter int IMG_SIZE = 19200,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    image_encrypter_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_SIZE - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [63:0]       key_q, key_d;
    logic [7:0]        enc_q, enc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        mixed;

    // next state, counter/key/ciphertext loads and status flags; a low encrypter_active freezes everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        enc_d   = enc_q;
        key_d   = key_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mixed   = bus.plain_data ^ 8'(key_q >> {cnt_q[2:0], 3'b000});
        if (bus.start && (state_q == IDLE || state_q == DONE)) begin
            state_d = READ;
            cnt_d   = '0;
            key_d   = bus.key;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (bus.encrypter_active) begin
            case (state_q)
                READ:    state_d = CAPTURE;
                CAPTURE: begin
                    state_d = WRITE;
                    waddr_d = cnt_q;
                    enc_d   = {mixed[4:0], mixed[7:5]} ^ 8'(cnt_q);
                end
                WRITE: begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // state and datapath registers, cleared asynchronously so a reset aborts any pass at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            enc_q   <= '0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            enc_q   <= enc_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // the counter only moves between bytes, so it doubles as the ROM address held through READ and CAPTURE
    assign bus.read_addr      = cnt_q;
    assign bus.write_addr     = waddr_q;
    assign bus.encrypted_data = enc_q;
    assign bus.write_en       = (state_q == WRITE) && bus.encrypter_active;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_image_encrypter.sv
// tb_image_encrypter: randomized self-checking bench for image_encrypter against a cipher and timing model
module tb_image_encrypter;
    localparam int N  = 12;
    localparam int AW = 15;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    int         cyc   = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rom [0:15];
    int         wa_log[$];
    int         wd_log[$];
    int         wc_log[$];
    int         act_total = 0;
    int         stray = 0;

    image_encrypter_if #(.ADDR_W(AW)) bus ();

    image_encrypter #(.IMG_SIZE(N), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous ROM: data for the presented address appears after the next rising edge
    always @(posedge clk) bus.plain_data <= (int'(bus.read_addr) < N) ? rom[bus.read_addr[3:0]] : 8'h00;

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.write_en) begin
            wa_log.push_back(int'(bus.write_addr));
            wd_log.push_back(int'(bus.encrypted_data));
            wc_log.push_back(cyc);
            if (!bus.busy) stray++;
        end
        if (bus.busy && bus.encrypter_active) act_total++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    // cipher reference: xor with key byte (addr mod 8), rotate left 3, xor low address byte
    function automatic int model(int a, logic [63:0] k, int p);
        int x;
        x = p ^ int'((k >> (8 * (a % 8))) & 64'hFF);
        x = (x * 8) % 256 + x / 32;
        return x ^ (a % 256);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    endtask

    // runs one pass from a start pulse until done is seen; st is the cycle in which start was high
    task automatic do_pass(input logic [63:0] k, input logic [63:0] k_late, input int pause_at,
                           input int pause_len, input bit rnd, input bit poke, output int st);
        int t;
        int rel;
        t = 0;
        bus.key = k;
        bus.start = 1'b1;
        st = cyc;
        tick();
        bus.start = 1'b0;
        bus.key = k_late;
        while (!bus.done && t < 3 * N + pause_len + 300) begin
            rel = cyc - st;
            if (rnd) bus.encrypter_active = ($urandom_range(0, 2) != 0);
            else bus.encrypter_active = !(rel >= pause_at && rel < pause_at + pause_len);
            bus.start = poke && (rel == 10);
            tick();
            t++;
        end
        bus.encrypter_active = 1'b1;
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL pass_timeout: done=%b after %0d cycles, required 1", bus.done, t);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.key = '1;
        bus.encrypter_active = 1'b1;
        fill_rom();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.write_en, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: we/busy/done=%b, required 000", {bus.write_en, bus.busy, bus.done});
        end
        checks++;
        if (bus.read_addr !== '0 || bus.write_addr !== '0 || bus.encrypted_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: raddr=%0h waddr=%0h data=%0h, required 0 0 0",
                     bus.read_addr, bus.write_addr, bus.encrypted_data);
        end
        reset = 1'b1;
        repeat (4) tick();
        checks++;
        if (wa_log.size() != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: writes=%0d busy=%b done=%b, required 0 0 0", wa_log.size(), bus.busy, bus.done);
        end
    endtask

    task automatic test_first_byte();
        int st;
        int b;
        fill_rom();
        rom[0] = 8'h81;
        b = wa_log.size();
        do_pass(64'h0, 64'h0, 0, 0, 1'b0, 1'b0, st);
        checks++;
        if (wa_log.size() - b != N) begin
            errors++;
            $display("FAIL first_count: writes=%0d, required %0d", wa_log.size() - b, N);
        end else begin
            checks++;
            if (wc_log[b] - st != 3) begin
                errors++;
                $display("FAIL first_latency: write at cycle +%0d, required +3", wc_log[b] - st);
            end
            checks++;
            if (wa_log[b] != 0 || wd_log[b] != 8'h0C) begin
                errors++;
                $display("FAIL first_byte: addr %0d data %02h, required addr 0 data 0c", wa_log[b], wd_log[b]);
            end
        end
    endtask

    task automatic test_key_ff();
        int st;
        int b;
        logic [63:0] k;
        fill_rom();
        rom[0] = 8'h00;
        k = {32'($urandom), 24'($urandom), 8'hFF};
        b = wa_log.size();
        do_pass(k, k, 0, 0, 1'b0, 1'b0, st);
        checks++;
        if (wa_log.size() <= b || wa_log[b] != 0 || wd_log[b] != 8'hFF) begin
            errors++;
            $display("FAIL key_ff: addr %0d data %02h, required addr 0 data ff",
                     wa_log.size() > b ? wa_log[b] : -1, wd_log.size() > b ? wd_log[b] : -1);
        end
    endtask

    task automatic test_full_pass();
        int st;
        int b;
        logic [63:0] k;
        fill_rom();
        rom[9] = 8'hF0;
        k = {32'($urandom), 16'($urandom), 8'h0F, 8'($urandom)};
        b = wa_log.size();
        do_pass(k, ~k, 0, 0, 1'b0, 1'b0, st);
        checks++;
        if (wa_log.size() - b != N) begin
            errors++;
            $display("FAIL full_count: writes=%0d, required %0d", wa_log.size() - b, N);
        end
        for (int i = 0; i < N && b + i < wa_log.size(); i++) begin
            checks++;
            if (wa_log[b+i] != i || wd_log[b+i] != model(i, k, rom[i]) || wc_log[b+i] - st != 3 * (i + 1)) begin
                errors++;
                $display("FAIL full_write%0d: addr %0d data %02h cycle +%0d, required addr %0d data %02h cycle +%0d",
                         i, wa_log[b+i], wd_log[b+i], wc_log[b+i] - st, i, model(i, k, rom[i]), 3 * (i + 1));
            end
        end
        checks++;
        if (wa_log.size() > b + 9 && wd_log[b+9] != 8'hF6) begin
            errors++;
            $display("FAIL key_latch: addr 9 data %02h, required f6", wd_log[b+9]);
        end
        checks++;
        if (cyc - st != 3 * N + 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_timing: done at +%0d busy=%b, required +%0d busy=0", cyc - st, bus.busy, 3 * N + 1);
        end
    endtask

    task automatic test_pause();
        int st;
        int b;
        int a0;
        logic [63:0] k;
        fill_rom();
        k = {32'($urandom), 32'($urandom)};
        b = wa_log.size();
        a0 = act_total;
        do_pass(k, k, 8, 10, 1'b0, 1'b0, st);
        checks++;
        if (wa_log.size() - b != N) begin
            errors++;
            $display("FAIL pause_count: writes=%0d, required %0d", wa_log.size() - b, N);
        end else begin
            checks++;
            if (wc_log[b+1] - st != 6 || wc_log[b+2] - st != 19) begin
                errors++;
                $display("FAIL pause_gap: writes at +%0d,+%0d, required +6,+19", wc_log[b+1] - st, wc_log[b+2] - st);
            end
            checks++;
            if (wa_log[b+2] != 2 || wd_log[b+2] != model(2, k, rom[2])) begin
                errors++;
                $display("FAIL pause_byte: addr %0d data %02h, required addr 2 data %02h",
                         wa_log[b+2], wd_log[b+2], model(2, k, rom[2]));
            end
        end
        checks++;
        if (cyc - st != 3 * N + 11 || act_total - a0 != 3 * N) begin
            errors++;
            $display("FAIL pause_length: done at +%0d active=%0d, required +%0d active=%0d",
                     cyc - st, act_total - a0, 3 * N + 11, 3 * N);
        end
    endtask

    task automatic test_random_active();
        int st;
        int b;
        int a0;
        logic [63:0] k;
        for (int r = 0; r < 3; r++) begin
            fill_rom();
            k = {32'($urandom), 32'($urandom)};
            b = wa_log.size();
            a0 = act_total;
            do_pass(k, {32'($urandom), 32'($urandom)}, 0, 0, 1'b1, 1'b0, st);
            checks++;
            if (wa_log.size() - b != N || act_total - a0 != 3 * N) begin
                errors++;
                $display("FAIL rand%0d_count: writes=%0d active=%0d, required %0d %0d",
                         r, wa_log.size() - b, act_total - a0, N, 3 * N);
            end
            for (int i = 0; i < N && b + i < wa_log.size(); i++) begin
                checks++;
                if (wa_log[b+i] != i || wd_log[b+i] != model(i, k, rom[i])) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: addr %0d data %02h, required addr %0d data %02h",
                             r, i, wa_log[b+i], wd_log[b+i], i, model(i, k, rom[i]));
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int st;
        int b;
        logic [63:0] k;
        fill_rom();
        k = {32'($urandom), 32'($urandom)};
        b = wa_log.size();
        do_pass(k, k, 0, 0, 1'b0, 1'b1, st);
        checks++;
        if (wa_log.size() - b != N || cyc - st != 3 * N + 1) begin
            errors++;
            $display("FAIL busy_start: writes=%0d done at +%0d, required %0d +%0d",
                     wa_log.size() - b, cyc - st, N, 3 * N + 1);
        end
        for (int i = 0; i < N && b + i < wa_log.size(); i++) begin
            checks++;
            if (wa_log[b+i] != i || wd_log[b+i] != model(i, k, rom[i])) begin
                errors++;
                $display("FAIL busy_write%0d: addr %0d data %02h, required addr %0d data %02h",
                         i, wa_log[b+i], wd_log[b+i], i, model(i, k, rom[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int st;
        int b;
        logic [63:0] k;
        fill_rom();
        k = {32'($urandom), 32'($urandom)};
        bus.key = k;
        bus.start = 1'b1;
        st = cyc;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.write_en !== 1'b1 || bus.write_addr !== AW'(1)) begin
            errors++;
            $display("FAIL mid_write: we=%b addr=%0d at +%0d, required we=1 addr=1", bus.write_en, bus.write_addr, cyc - st);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.write_en, bus.busy, bus.done} !== 3'b000 || bus.write_addr !== '0 ||
            bus.read_addr !== '0 || bus.encrypted_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: we/busy/done=%b waddr=%0d raddr=%0d data=%02h, required all 0",
                     {bus.write_en, bus.busy, bus.done}, bus.write_addr, bus.read_addr, bus.encrypted_data);
        end
        repeat (2) tick();
        reset = 1'b1;
        b = wa_log.size();
        repeat (5) tick();
        checks++;
        if (wa_log.size() != b || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: writes=%0d busy=%b, required 0 0", wa_log.size() - b, bus.busy);
        end
        do_pass(k, k, 0, 0, 1'b0, 1'b0, st);
        checks++;
        if (wa_log.size() - b != N || wa_log[b] != 0 || wc_log[b] - st != 3 || wd_log[b] != model(0, k, rom[0])) begin
            errors++;
            $display("FAIL restart: writes=%0d first addr %0d at +%0d data %02h, required %0d addr 0 at +3 data %02h",
                     wa_log.size() - b, wa_log.size() > b ? wa_log[b] : -1, wc_log.size() > b ? wc_log[b] - st : -1,
                     wd_log.size() > b ? wd_log[b] : -1, N, model(0, k, rom[0]));
        end
    endtask

    task automatic test_no_stray();
        repeat (5) tick();
        checks++;
        if (stray != 0 || bus.write_en !== 1'b0) begin
            errors++;
            $display("FAIL stray_writes: writes outside busy=%0d we=%b, required 0 0", stray, bus.write_en);
        end
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_key_ff();
        test_full_pass();
        test_pause();
        test_random_active();
        test_start_while_busy();
        test_reset_mid();
        test_no_stray();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
